// File: rtl/jogo_pkg.sv
// Shared constants for the game control unit.
// State codes are the 4-bit values shown on db_estado; DISPLAY_BITS sizes the
// display multiplex count.
package jogo_pkg;

  localparam int unsigned STATE_BITS   = 4;
  localparam int unsigned DISPLAY_BITS = 2;

  localparam logic [3:0] INICIAL         = 4'h0;
  localparam logic [3:0] MOSTRA_MSG      = 4'h1;
  localparam logic [3:0] AVANCA_MSG      = 4'h2;
  localparam logic [3:0] REGISTRA_MUSICA = 4'h3;
  localparam logic [3:0] PREPARA_RODADA  = 4'h4;
  localparam logic [3:0] TOCA_NOTA       = 4'h5;
  localparam logic [3:0] PROXIMA_DEMO    = 4'h6;
  localparam logic [3:0] ESPERA_JOGADA   = 4'h7;
  localparam logic [3:0] REGISTRA_JOGADA = 4'h8;
  localparam logic [3:0] COMPARA         = 4'h9;
  localparam logic [3:0] CONTA_ERRO      = 4'hA;
  localparam logic [3:0] PROXIMA_JOGADA  = 4'hB;
  localparam logic [3:0] CALCULA_PONTOS  = 4'hC;
  localparam logic [3:0] PROXIMA_RODADA  = 4'hD;
  localparam logic [3:0] FIM_JOGO        = 4'hE;
  localparam logic [3:0] FIM_DEMO        = 4'hF;

endpackage

// File: rtl/unidade_controle_jogo_divisor_display.sv
// divisor_display: prescaler that advances the 2-bit display digit index once
// every DIV_DISPLAY clock cycles, wrapping 3 -> 0.
// Ports: clock, reset (sync, active-high), contagem_display (digit index).
module divisor_display
  import jogo_pkg::*;
#(
  parameter int unsigned DIV_DISPLAY = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [DISPLAY_BITS-1:0] contagem_display
);

  localparam int unsigned DIV_W = (DIV_DISPLAY > 1) ? $clog2(DIV_DISPLAY) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_DISPLAY - 1);

  logic [DIV_W-1:0] divisor;
  logic             passo;

  assign passo = (divisor == DIV_LAST);

  // Prescaler and wrap counter; the counter only moves on the prescaler's last cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      divisor          <= '0;
      contagem_display <= '0;
    end else if (passo) begin
      divisor          <= '0;
      contagem_display <= contagem_display + DISPLAY_BITS'(1);
    end else begin
      divisor          <= divisor + DIV_W'(1);
    end
  end

endmodule

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing the game datapath (intro message,
// music selection, per-round demo, player input/compare, scoring) and owning
// the display multiplex count.
// Ports: clock, reset (sync, active-high), iniciar, datapath condition inputs,
// one control output per datapath enable/clear/select, contagem_display, db_estado.
// Build option: define TIMEOUT_JOGADA_EN to time out player input in
// ESPERA_JOGADA and count a missed note as one error.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int unsigned DIV_DISPLAY = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic                    botoesIgualMemoria,
  input  logic                    enderecoIgualLimite,
  input  logic                    fimL,
  input  logic                    tem_botao_pressionado,
  input  logic                    tem_jogada,
  input  logic                    timeout_contador_buzzer,
  input  logic                    timeout_contador_msg,
  output logic                    activate_arduino,
  output logic                    calcular_pontos,
  output logic                    enable_contador_erro,
  output logic                    enable_contador_jogada,
  output logic                    enable_contador_msg,
  output logic                    enable_contador_rodada,
  output logic                    enable_registrador_botoes,
  output logic                    enable_registrador_musica,
  output logic                    enable_registrador_pontos,
  output logic                    enable_timer_buzzer,
  output logic                    enable_timer_msg,
  output logic                    select_mux_arduino,
  output logic                    select_mux_letra,
  output logic                    zera_contador_erro,
  output logic                    zera_contador_jogada,
  output logic                    zera_contador_msg,
  output logic                    zera_contador_rodada,
  output logic                    zera_registrador_botoes,
  output logic                    zera_registrador_pontos,
  output logic                    zera_timer_buzzer,
  output logic                    zera_timer_msg,
  output logic [DISPLAY_BITS-1:0] contagem_display,
  output logic [STATE_BITS-1:0]   db_estado
);

  logic [STATE_BITS-1:0] estado;
  logic [STATE_BITS-1:0] estado_prox;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= estado_prox;
  end

  // Next state and Moore output decode.
  always_comb begin
    estado_prox               = estado;
    activate_arduino          = 1'b0;
    calcular_pontos           = 1'b0;
    enable_contador_erro      = 1'b0;
    enable_contador_jogada    = 1'b0;
    enable_contador_msg       = 1'b0;
    enable_contador_rodada    = 1'b0;
    enable_registrador_botoes = 1'b0;
    enable_registrador_musica = 1'b0;
    enable_registrador_pontos = 1'b0;
    enable_timer_buzzer       = 1'b0;
    enable_timer_msg          = 1'b0;
    select_mux_arduino        = 1'b0;
    select_mux_letra          = 1'b0;
    zera_contador_erro        = 1'b0;
    zera_contador_jogada      = 1'b0;
    zera_contador_msg         = 1'b0;
    zera_contador_rodada      = 1'b0;
    zera_registrador_botoes   = 1'b0;
    zera_registrador_pontos   = 1'b0;
    zera_timer_buzzer         = 1'b0;
    zera_timer_msg            = 1'b0;

    case (estado)
      INICIAL: begin
        zera_contador_erro      = 1'b1;
        zera_contador_jogada    = 1'b1;
        zera_contador_msg       = 1'b1;
        zera_contador_rodada    = 1'b1;
        zera_registrador_botoes = 1'b1;
        zera_registrador_pontos = 1'b1;
        zera_timer_buzzer       = 1'b1;
        zera_timer_msg          = 1'b1;
        estado_prox             = MOSTRA_MSG;
      end
      MOSTRA_MSG: begin
        enable_timer_msg = 1'b1;
        // A press selects the music even if the scroll timer expires the same cycle.
        if (tem_jogada)                estado_prox = REGISTRA_MUSICA;
        else if (timeout_contador_msg) estado_prox = AVANCA_MSG;
      end
      AVANCA_MSG: begin
        enable_contador_msg = 1'b1;
        zera_timer_msg      = 1'b1;
        estado_prox         = MOSTRA_MSG;
      end
      REGISTRA_MUSICA: begin
        enable_registrador_musica = 1'b1;
        estado_prox               = PREPARA_RODADA;
      end
      PREPARA_RODADA: begin
        zera_contador_jogada = 1'b1;
        zera_contador_erro   = 1'b1;
        zera_timer_buzzer    = 1'b1;
        estado_prox          = TOCA_NOTA;
      end
      TOCA_NOTA: begin
        select_mux_arduino  = 1'b1;
        activate_arduino    = 1'b1;
        enable_timer_buzzer = 1'b1;
        select_mux_letra    = 1'b1;
        if (timeout_contador_buzzer) estado_prox = PROXIMA_DEMO;
      end
      PROXIMA_DEMO: begin
        zera_timer_buzzer = 1'b1;
        if (enderecoIgualLimite) begin
          estado_prox = FIM_DEMO;
        end else begin
          enable_contador_jogada = 1'b1;
          estado_prox            = TOCA_NOTA;
        end
      end
      FIM_DEMO: begin
        zera_contador_jogada    = 1'b1;
        zera_registrador_botoes = 1'b1;
        zera_timer_buzzer       = 1'b1;
        estado_prox             = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        select_mux_letra = 1'b1;
        // Live button echo to the sound generator while waiting.
        activate_arduino = tem_botao_pressionado;
`ifdef TIMEOUT_JOGADA_EN
        enable_timer_buzzer = 1'b1;
        if (tem_jogada)                   estado_prox = REGISTRA_JOGADA;
        else if (timeout_contador_buzzer) estado_prox = CONTA_ERRO;
`else
        if (tem_jogada) estado_prox = REGISTRA_JOGADA;
`endif
      end
      REGISTRA_JOGADA: begin
        // Extra cycle so the button register and ROM output settle before compare.
        enable_registrador_botoes = 1'b1;
        estado_prox               = COMPARA;
      end
      COMPARA: begin
        if (!botoesIgualMemoria)      estado_prox = CONTA_ERRO;
        else if (enderecoIgualLimite) estado_prox = CALCULA_PONTOS;
        else                          estado_prox = PROXIMA_JOGADA;
      end
      CONTA_ERRO: begin
        enable_contador_erro = 1'b1;
        if (enderecoIgualLimite) estado_prox = CALCULA_PONTOS;
        else                     estado_prox = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: begin
        enable_contador_jogada = 1'b1;
        zera_timer_buzzer      = 1'b1;
        estado_prox            = ESPERA_JOGADA;
      end
      CALCULA_PONTOS: begin
        calcular_pontos           = 1'b1;
        enable_registrador_pontos = 1'b1;
        if (fimL) estado_prox = FIM_JOGO;
        else      estado_prox = PROXIMA_RODADA;
      end
      PROXIMA_RODADA: begin
        enable_contador_rodada = 1'b1;
        estado_prox            = PREPARA_RODADA;
      end
      FIM_JOGO: begin
        select_mux_letra = 1'b1;
        if (iniciar) estado_prox = INICIAL;
      end
      default: estado_prox = INICIAL;
    endcase
  end

  assign db_estado = estado;

  divisor_display #(
    .DIV_DISPLAY (DIV_DISPLAY)
  ) u_divisor_display (
    .clock            (clock),
    .reset            (reset),
    .contagem_display (contagem_display)
  );

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo: walks the game flow through its
// phases with hand-computed state codes and output levels.
// Honours TIMEOUT_JOGADA_EN the same way as the design.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       botoesIgualMemoria;
  logic       enderecoIgualLimite;
  logic       fimL;
  logic       tem_botao_pressionado;
  logic       tem_jogada;
  logic       timeout_contador_buzzer;
  logic       timeout_contador_msg;
  logic       activate_arduino;
  logic       calcular_pontos;
  logic       enable_contador_erro;
  logic       enable_contador_jogada;
  logic       enable_contador_msg;
  logic       enable_contador_rodada;
  logic       enable_registrador_botoes;
  logic       enable_registrador_musica;
  logic       enable_registrador_pontos;
  logic       enable_timer_buzzer;
  logic       enable_timer_msg;
  logic       select_mux_arduino;
  logic       select_mux_letra;
  logic       zera_contador_erro;
  logic       zera_contador_jogada;
  logic       zera_contador_msg;
  logic       zera_contador_rodada;
  logic       zera_registrador_botoes;
  logic       zera_registrador_pontos;
  logic       zera_timer_buzzer;
  logic       zera_timer_msg;
  logic [1:0] contagem_display;
  logic [3:0] db_estado;

  int vectors;
  int miscompares;
  int n_msg, n_err, n_calc, n_toca;

  unidade_controle_jogo #(.DIV_DISPLAY(4)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .iniciar                   (iniciar),
    .botoesIgualMemoria        (botoesIgualMemoria),
    .enderecoIgualLimite       (enderecoIgualLimite),
    .fimL                      (fimL),
    .tem_botao_pressionado     (tem_botao_pressionado),
    .tem_jogada                (tem_jogada),
    .timeout_contador_buzzer   (timeout_contador_buzzer),
    .timeout_contador_msg      (timeout_contador_msg),
    .activate_arduino          (activate_arduino),
    .calcular_pontos           (calcular_pontos),
    .enable_contador_erro      (enable_contador_erro),
    .enable_contador_jogada    (enable_contador_jogada),
    .enable_contador_msg       (enable_contador_msg),
    .enable_contador_rodada    (enable_contador_rodada),
    .enable_registrador_botoes (enable_registrador_botoes),
    .enable_registrador_musica (enable_registrador_musica),
    .enable_registrador_pontos (enable_registrador_pontos),
    .enable_timer_buzzer       (enable_timer_buzzer),
    .enable_timer_msg          (enable_timer_msg),
    .select_mux_arduino        (select_mux_arduino),
    .select_mux_letra          (select_mux_letra),
    .zera_contador_erro        (zera_contador_erro),
    .zera_contador_jogada      (zera_contador_jogada),
    .zera_contador_msg         (zera_contador_msg),
    .zera_contador_rodada      (zera_contador_rodada),
    .zera_registrador_botoes   (zera_registrador_botoes),
    .zera_registrador_pontos   (zera_registrador_pontos),
    .zera_timer_buzzer         (zera_timer_buzzer),
    .zera_timer_msg            (zera_timer_msg),
    .contagem_display          (contagem_display),
    .db_estado                 (db_estado)
  );

  always #5 clock = ~clock;

  logic [7:0]  zeras;
  logic [12:0] outros;
  assign zeras = {zera_contador_erro, zera_contador_jogada, zera_contador_msg,
                  zera_contador_rodada, zera_registrador_botoes,
                  zera_registrador_pontos, zera_timer_buzzer, zera_timer_msg};
  assign outros = {activate_arduino, calcular_pontos, enable_contador_erro,
                   enable_contador_jogada, enable_contador_msg,
                   enable_contador_rodada, enable_registrador_botoes,
                   enable_registrador_musica, enable_registrador_pontos,
                   enable_timer_buzzer, enable_timer_msg, select_mux_arduino,
                   select_mux_letra};

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive at the falling edge.
  task automatic step();
    @(negedge clock);
    if (enable_contador_msg)  n_msg++;
    if (enable_contador_erro) n_err++;
    if (calcular_pontos)      n_calc++;
    if (db_estado == 4'h5 && select_mux_arduino) n_toca++;
  endtask

  task automatic go(input string tag, input logic [3:0] exp);
    step();
    chk(tag, 32'(db_estado), 32'(exp));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    n_msg = 0; n_err = 0; n_calc = 0; n_toca = 0;
    reset = 1'b1; iniciar = 1'b0; botoesIgualMemoria = 1'b0;
    enderecoIgualLimite = 1'b0; fimL = 1'b0; tem_botao_pressionado = 1'b0;
    tem_jogada = 1'b0; timeout_contador_buzzer = 1'b0; timeout_contador_msg = 1'b0;

    // Reset state.
    step(); step();
    chk("rst_estado", 32'(db_estado), 32'h0);
    chk("rst_zeras", 32'(zeras), 32'hFF);
    chk("rst_outros", 32'(outros), 32'h0);
    chk("rst_display", 32'(contagem_display), 32'h0);

    // Display count: after n clocks out of reset it reads (n/4)%4.
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("display", 32'(contagem_display), 32'((n / 4) % 4));
      if (n == 1) begin
        chk("msg_estado", 32'(db_estado), 32'h1);
        chk("msg_timer_en", 32'(enable_timer_msg), 32'h1);
        chk("msg_letra", 32'(select_mux_letra), 32'h0);
      end
    end
    chk("msg_hold", 32'(db_estado), 32'h1);

    // Three scroll steps.
    n_msg = 0;
    for (int i = 0; i < 3; i++) begin
      timeout_contador_msg = 1'b1;
      go("avanca", 4'h2);
      timeout_contador_msg = 1'b0;
      go("volta_msg", 4'h1);
    end
    chk("n_en_msg", 32'(n_msg), 32'd3);

    // Press wins over simultaneous scroll timeout.
    tem_jogada = 1'b1; timeout_contador_msg = 1'b1;
    go("reg_musica", 4'h3);
    tem_jogada = 1'b0; timeout_contador_msg = 1'b0;
    chk("en_reg_musica", 32'(enable_registrador_musica), 32'h1);
    go("prepara", 4'h4);
    go("toca", 4'h5);

    // Demo note lasts 10 cycles, then 6 -> F -> 7.
    n_toca = 1;
    chk("toca_outs", 32'({select_mux_arduino, activate_arduino, enable_timer_buzzer, select_mux_letra}), 32'hF);
    for (int i = 0; i < 9; i++) step();
    enderecoIgualLimite = 1'b1; timeout_contador_buzzer = 1'b1;
    chk("n_toca", 32'(n_toca), 32'd10);
    go("prox_demo", 4'h6);
    timeout_contador_buzzer = 1'b0;
    chk("prox_demo_en_jog", 32'(enable_contador_jogada), 32'h0);
    go("fim_demo", 4'hF);
    chk("fim_demo_zera", 32'(zeras), 32'b01001010);
    go("espera", 4'h7);

    // Button echo is combinational in ESPERA_JOGADA.
    tem_botao_pressionado = 1'b1; #1;
    chk("echo_on", 32'(activate_arduino), 32'h1);
    tem_botao_pressionado = 1'b0; #1;
    chk("echo_off", 32'(activate_arduino), 32'h0);
    chk("espera_outs", 32'({select_mux_letra, select_mux_arduino}), 32'b10);

    // Wrong press on last note, not final round.
    n_err = 0; n_calc = 0;
    tem_jogada = 1'b1; botoesIgualMemoria = 1'b0; fimL = 1'b0;
    go("reg_jogada", 4'h8);
    tem_jogada = 1'b0;
    go("compara", 4'h9);
    go("conta_erro", 4'hA);
    go("calcula", 4'hC);
    go("prox_rodada", 4'hD);
    chk("en_rodada", 32'(enable_contador_rodada), 32'h1);
    go("prepara2", 4'h4);
    chk("n_err", 32'(n_err), 32'd1);
    chk("n_calc", 32'(n_calc), 32'd1);

    // Reset held two cycles in the middle of a demo note.
    go("toca2", 4'h5);
    reset = 1'b1;
    step(); step();
    chk("mid_rst_estado", 32'(db_estado), 32'h0);
    chk("mid_rst_zeras", 32'(zeras), 32'hFF);
    chk("mid_rst_display", 32'(contagem_display), 32'h0);
    reset = 1'b0;
    go("mid_rst_msg", 4'h1);

    // Final round: reach FIM_JOGO.
    tem_jogada = 1'b1;
    go("reg_musica2", 4'h3);
    tem_jogada = 1'b0;
    go("prepara3", 4'h4);
    go("toca3", 4'h5);
    enderecoIgualLimite = 1'b0; timeout_contador_buzzer = 1'b1;
    go("prox_demo2", 4'h6);
    chk("demo_en_jog", 32'(enable_contador_jogada), 32'h1);
    timeout_contador_buzzer = 1'b0;
    go("toca4", 4'h5);
    enderecoIgualLimite = 1'b1; timeout_contador_buzzer = 1'b1;
    go("prox_demo3", 4'h6);
    timeout_contador_buzzer = 1'b0;
    go("fim_demo2", 4'hF);
    go("espera2", 4'h7);

`ifdef TIMEOUT_JOGADA_EN
    chk("espera_timer_en", 32'(enable_timer_buzzer), 32'h1);
    enderecoIgualLimite = 1'b0; timeout_contador_buzzer = 1'b1;
    go("timeout_erro", 4'hA);
    timeout_contador_buzzer = 1'b0;
    go("timeout_prox", 4'hB);
    go("timeout_espera", 4'h7);
    enderecoIgualLimite = 1'b1;
`else
    chk("espera_timer_en", 32'(enable_timer_buzzer), 32'h0);
    timeout_contador_buzzer = 1'b1;
    go("espera_ignora_to", 4'h7);
    timeout_contador_buzzer = 1'b0;
`endif

    tem_jogada = 1'b1; botoesIgualMemoria = 1'b1; fimL = 1'b1;
    go("reg_jogada2", 4'h8);
    tem_jogada = 1'b0;
    go("compara2", 4'h9);
    go("calcula2", 4'hC);
    go("fim_jogo", 4'hE);
    for (int i = 0; i < 49; i++) step();
    chk("fim_hold", 32'(db_estado), 32'hE);
    chk("fim_letra", 32'(select_mux_letra), 32'h1);
    iniciar = 1'b1;
    go("reinicia", 4'h0);
    iniciar = 1'b0;
    go("reinicia_msg", 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore FSM that sequences the game datapath (fluxo_dados) through its phases:
  - scrolling intro message;
  - music selection;
  - per-round demo playback of the stored notes;
  - player input, with comparison and error counting;
  - point calculation and round advance.
- Also generates the 2-bit display-multiplex count shared by the message and letter paths.
- Sits between the top level and fluxo_dados, driving every control input and consuming every condition output.

Parameters:
- DIV_DISPLAY, 4: clock cycles per contagem_display step (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; state → INICIAL
- iniciar  in  1  start/restart request (level)
- botoesIgualMemoria, enderecoIgualLimite, fimL, tem_botao_pressionado, tem_jogada, timeout_contador_buzzer, timeout_contador_msg  in  1 each  datapath conditions
- activate_arduino, calcular_pontos, enable_contador_erro, enable_contador_jogada, enable_contador_msg, enable_contador_rodada, enable_registrador_botoes, enable_registrador_musica, enable_registrador_pontos, enable_timer_buzzer, enable_timer_msg, select_mux_arduino, select_mux_letra  out  1 each
- zera_contador_erro, zera_contador_jogada, zera_contador_msg, zera_contador_rodada, zera_registrador_botoes, zera_registrador_pontos, zera_timer_buzzer, zera_timer_msg  out  1 each
- contagem_display  out  2  display digit index
- db_estado  out  4  current state code

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clock and reset.
- Reset takes priority over all transitions, including mid-round.
- Values after reset:
  - state INICIAL, db_estado=0;
  - all zera_* = 1, every other control = 0;
  - contagem_display = 0, divider = 0.
- Outputs are decoded from state only (Moore). The one exception is activate_arduino in ESPERA_JOGADA, which equals tem_botao_pressionado.
- Outputs not listed for a state are 0. Each state lists code, outputs, then next state.
- INICIAL (0): all zera_*=1 → MOSTRA_MSG.
- MOSTRA_MSG (1): enable_timer_msg, select_mux_letra=0.
  - tem_jogada → REGISTRA_MUSICA; this has priority over the timeout.
  - Otherwise timeout_contador_msg → AVANCA_MSG.
- AVANCA_MSG (2): enable_contador_msg, zera_timer_msg → MOSTRA_MSG. The message counter wraps inside the datapath.
- REGISTRA_MUSICA (3): enable_registrador_musica → PREPARA_RODADA.
- PREPARA_RODADA (4): zera_contador_jogada, zera_contador_erro, zera_timer_buzzer → TOCA_NOTA.
- TOCA_NOTA (5): select_mux_arduino=1, activate_arduino, enable_timer_buzzer, select_mux_letra=1.
  - timeout_contador_buzzer → PROXIMA_DEMO.
  - The ROM's one-cycle latency is absorbed by the timer duration.
- PROXIMA_DEMO (6): zera_timer_buzzer.
  - enderecoIgualLimite → FIM_DEMO.
  - Otherwise enable_contador_jogada=1 in this state, then → TOCA_NOTA.
- FIM_DEMO (F): zera_contador_jogada, zera_registrador_botoes, zera_timer_buzzer → ESPERA_JOGADA.
- ESPERA_JOGADA (7): select_mux_letra=1, select_mux_arduino=0, activate_arduino=tem_botao_pressionado.
  - tem_jogada → REGISTRA_JOGADA.
- REGISTRA_JOGADA (8): enable_registrador_botoes → COMPARA. The extra cycle lets the register and ROM settle.
- COMPARA (9):
  - !botoesIgualMemoria → CONTA_ERRO.
  - Else enderecoIgualLimite → CALCULA_PONTOS.
  - Else → PROXIMA_JOGADA.
- CONTA_ERRO (A): enable_contador_erro.
  - enderecoIgualLimite → CALCULA_PONTOS; else → PROXIMA_JOGADA.
- PROXIMA_JOGADA (B): enable_contador_jogada, zera_timer_buzzer → ESPERA_JOGADA.
- CALCULA_PONTOS (C): calcular_pontos, enable_registrador_pontos.
  - fimL → FIM_JOGO; else → PROXIMA_RODADA.
- PROXIMA_RODADA (D): enable_contador_rodada → PREPARA_RODADA.
- FIM_JOGO (E): select_mux_letra=1; holds; iniciar → INICIAL.
- Round limit:
  - Round n plays n+1 notes (addresses 0..n).
  - The final round is limite=15, where fimL=1.
  - The limit counter never wraps inside a game.
- contagem_display:
  - Increments modulo 4 each DIV_DISPLAY cycles in every state and wraps 3→0.
  - Reset zeroes it; it is not zeroed by state changes.

Optional Feature:
- Macro: TIMEOUT_JOGADA_EN.
- Defined: ESPERA_JOGADA also asserts enable_timer_buzzer.
  - timeout_contador_buzzer without tem_jogada → CONTA_ERRO, i.e. a missed note counts as one error.
  - Simultaneous tem_jogada and timeout: tem_jogada wins.
- Undefined: ESPERA_JOGADA waits indefinitely and enable_timer_buzzer=0 there.

Decomposition:
- Package jogo_pkg: 4-bit state localparams (INICIAL..FIM_DEMO) and DISPLAY_BITS=2.
- One sub-module, divisor_display: a DIV_DISPLAY prescaler plus the 2-bit wrap counter.

Test Plan:
- Reset held 2 cycles mid-TOCA_NOTA → db_estado=0, all zera_*=1, contagem_display=0. Next cycle db_estado=1.
- In MOSTRA_MSG, pulse timeout_contador_msg 3× → AVANCA_MSG visited 3×, enable_contador_msg high exactly 3 cycles. Then tem_jogada → 3→4→5.
- Round 0 with enderecoIgualLimite=1, buzzer timeout after 10 cycles → TOCA_NOTA holds 10 cycles with select_mux_arduino=1, then 6→F→7.
- Press with botoesIgualMemoria=0, enderecoIgualLimite=1, fimL=0 → states 8,9,A,C,D,4; enable_contador_erro exactly 1 cycle; calcular_pontos exactly 1 cycle.
- fimL=1 in CALCULA_PONTOS → FIM_JOGO holds 50 cycles; iniciar=1 → INICIAL.
- DIV_DISPLAY=4, 16 cycles → contagem_display 0,1,2,3,0. With TIMEOUT_JOGADA_EN, timeout in ESPERA_JOGADA → CONTA_ERRO.
